ssd1331_spi_receiver: RTL and testbench

SSD1331_SPI_RECEIVER -- requirements
Module: ssd1331_spi_receiver

---
 rtl/ssd1331_spi_receiver.sv | 221 ++++++++++++++++++++++
 tb/tb_ssd1331_spi_receiver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1331_spi_receiver.sv
// rtl/ssd1331_spi_receiver.sv - SSD1331-style SPI slave: byte assembly, command decode, windowed pixel writes
// Sampled in the i_CLK domain, so i_CLK must run at least 4x SCK.
module ssd1331_spi_receiver #(
  parameter int NUM_COL = 96,
  parameter int NUM_ROW = 64,
  parameter int WIDTH   = 8
) (
  input  logic                       i_CLK,
  input  logic                       i_RST,
  input  logic                       i_SCK,
  input  logic                       i_MOSI,
  input  logic                       i_CS,
  input  logic                       i_DC,
  output logic                       o_RX_VALID,
  output logic [WIDTH-1:0]           o_RX_BYTE,
  output logic                       o_RX_DC,
  output logic                       o_PIX_WE,
  output logic [$clog2(NUM_COL)-1:0] o_PIX_COL,
  output logic [$clog2(NUM_ROW)-1:0] o_PIX_ROW,
  output logic [WIDTH-1:0]           o_PIX_DATA,
  output logic                       o_DISPLAY_ON,
  output logic [7:0]                 o_REMAP,
  output logic                       o_FRAME_ERR,
  output logic                       o_UNKNOWN_CMD
);

  localparam int CW = $clog2(NUM_COL);
  localparam int RW = $clog2(NUM_ROW);
  localparam int BW = $clog2(WIDTH);
  localparam logic [7:0] COL_MAX = 8'(NUM_COL - 1);
  localparam logic [7:0] ROW_MAX = 8'(NUM_ROW - 1);

  typedef enum logic {ST_CMD, ST_PARAM} state_t;

  logic [1:0] sck_sync, mosi_sync, cs_sync, dc_sync;
  logic       sck_q, cs_q;
  logic       sck_s, mosi_s, cs_s, dc_s, sck_rise, cs_rise;

  assign sck_s    = sck_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign cs_s     = cs_sync[1];
  assign dc_s     = dc_sync[1];
  assign sck_rise = sck_s & ~sck_q;
  assign cs_rise  = cs_s & ~cs_q;

  // CS flops reset high so releasing reset never looks like a deselect
  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      dc_sync   <= 2'b00;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[0], i_SCK};
      mosi_sync <= {mosi_sync[0], i_MOSI};
      cs_sync   <= {cs_sync[0], i_CS};
      dc_sync   <= {dc_sync[0], i_DC};
      sck_q     <= sck_s;
      cs_q      <= cs_s;
    end
  end

  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-2:0] shift_q;

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      o_RX_VALID  <= 1'b0;
      o_RX_BYTE   <= '0;
      o_RX_DC     <= 1'b0;
      o_FRAME_ERR <= 1'b0;
    end else begin
      o_RX_VALID  <= 1'b0;
      o_FRAME_ERR <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
        if (cs_rise && bit_cnt != '0) o_FRAME_ERR <= 1'b1;
      end else if (sck_rise) begin
        shift_q <= {shift_q[WIDTH-3:0], mosi_s};
        if (bit_cnt == BW'(WIDTH - 1)) begin
          bit_cnt    <= '0;
          o_RX_BYTE  <= {shift_q, mosi_s};
          o_RX_DC    <= dc_s;
          o_RX_VALID <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] op_q, p0_q, rx8;
  logic       latch_op, store_p0, apply, disp_set, disp_clr, unk, pix;

  assign rx8 = 8'(o_RX_BYTE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_op = 1'b0;
    store_p0 = 1'b0;
    apply    = 1'b0;
    disp_set = 1'b0;
    disp_clr = 1'b0;
    unk      = 1'b0;
    pix      = 1'b0;
    if (o_RX_VALID) begin
      if (o_RX_DC) begin
        pix     = 1'b1;
        state_d = ST_CMD;
        cnt_d   = 2'd0;
      end else begin
        unique case (state_q)
          ST_CMD: begin
            case (rx8)
              8'hAF: disp_set = 1'b1;
              8'hAE: disp_clr = 1'b1;
              8'h15, 8'h75: begin
                latch_op = 1'b1;
                state_d  = ST_PARAM;
                cnt_d    = 2'd2;
              end
              8'hA0: begin
                latch_op = 1'b1;
                state_d  = ST_PARAM;
                cnt_d    = 2'd1;
              end
              default: unk = 1'b1;
            endcase
          end
          ST_PARAM: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd2) store_p0 = 1'b1;
            if (cnt_q == 2'd1) begin
              apply   = 1'b1;
              state_d = ST_CMD;
            end
          end
          default: state_d = ST_CMD;
        endcase
      end
    end
  end

  // First parameter is the window start, the byte in hand is the end
  logic [7:0] lim, win_lo, win_hi;

  always_comb begin
    lim    = (op_q == 8'h75) ? ROW_MAX : COL_MAX;
    win_lo = (p0_q > lim) ? lim : p0_q;
    win_hi = (rx8 > lim) ? lim : rx8;
    if (win_hi < win_lo) win_hi = win_lo;
  end

  logic [CW-1:0] col_start, col_end, col_ptr;
  logic [RW-1:0] row_start, row_end, row_ptr;

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state_q       <= ST_CMD;
      cnt_q         <= 2'd0;
      op_q          <= 8'h00;
      p0_q          <= 8'h00;
      col_start     <= '0;
      col_end       <= CW'(NUM_COL - 1);
      row_start     <= '0;
      row_end       <= RW'(NUM_ROW - 1);
      col_ptr       <= '0;
      row_ptr       <= '0;
      o_PIX_WE      <= 1'b0;
      o_PIX_COL     <= '0;
      o_PIX_ROW     <= '0;
      o_PIX_DATA    <= '0;
      o_DISPLAY_ON  <= 1'b0;
      o_REMAP       <= 8'h00;
      o_UNKNOWN_CMD <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      o_PIX_WE      <= pix;
      o_UNKNOWN_CMD <= unk;
      if (latch_op) op_q <= rx8;
      if (store_p0) p0_q <= rx8;
      if (disp_set) o_DISPLAY_ON <= 1'b1;
      if (disp_clr) o_DISPLAY_ON <= 1'b0;
      if (apply) begin
        case (op_q)
          8'h15: begin
            col_start <= CW'(win_lo);
            col_end   <= CW'(win_hi);
            col_ptr   <= CW'(win_lo);
          end
          8'h75: begin
            row_start <= RW'(win_lo);
            row_end   <= RW'(win_hi);
            row_ptr   <= RW'(win_lo);
          end
          default: o_REMAP <= rx8;
        endcase
      end
      if (pix) begin
        o_PIX_COL  <= col_ptr;
        o_PIX_ROW  <= row_ptr;
        o_PIX_DATA <= o_RX_BYTE;
        if (col_ptr == col_end) begin
          col_ptr <= col_start;
          row_ptr <= (row_ptr == row_end) ? row_start : row_ptr + 1'b1;
        end else begin
          col_ptr <= col_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd1331_spi_receiver.sv
// tb/tb_ssd1331_spi_receiver.sv - randomized self-checking bench with a transaction-level panel model
module tb_ssd1331_spi_receiver;

  logic       clk = 1'b0, rst = 1'b0, sck = 1'b0, mosi = 1'b0, cs = 1'b1, dc = 1'b0;
  logic       rx_valid, rx_dc, pix_we, disp_on, frame_err, unk_cmd;
  logic [7:0] rx_byte, pix_data, remap;
  logic [6:0] pix_col;
  logic [5:0] pix_row;

  ssd1331_spi_receiver dut (
    .i_CLK(clk), .i_RST(rst), .i_SCK(sck), .i_MOSI(mosi), .i_CS(cs), .i_DC(dc),
    .o_RX_VALID(rx_valid), .o_RX_BYTE(rx_byte), .o_RX_DC(rx_dc),
    .o_PIX_WE(pix_we), .o_PIX_COL(pix_col), .o_PIX_ROW(pix_row), .o_PIX_DATA(pix_data),
    .o_DISPLAY_ON(disp_on), .o_REMAP(remap), .o_FRAME_ERR(frame_err), .o_UNKNOWN_CMD(unk_cmd)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  // Panel model: opcode plus the list of parameters collected so far
  int m_disp, m_remap, m_op, m_need, m_busy;
  int m_params[$];
  int m_cs, m_ce, m_rs, m_re, m_col, m_row;
  int rxq[$], pixq[$];
  int exp_unk, exp_ferr;

  task automatic model_reset();
    m_disp = 0; m_remap = 0; m_op = 0; m_need = 0; m_busy = 0;
    m_params.delete();
    m_cs = 0; m_ce = 95; m_rs = 0; m_re = 63; m_col = 0; m_row = 0;
    rxq.delete(); pixq.delete();
    exp_unk = 0; exp_ferr = 0;
  endtask

  function automatic int clamp_max(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_byte(input int b, input int d);
    int s, e;
    rxq.push_back(d * 256 + b);
    if (d) begin
      pixq.push_back(m_col * 65536 + m_row * 256 + b);
      if (m_col == m_ce) begin
        m_col = m_cs;
        m_row = (m_row == m_re) ? m_rs : m_row + 1;
      end else m_col++;
      m_busy = 0;
      m_params.delete();
    end else if (!m_busy) begin
      case (b)
        'hAF: m_disp = 1;
        'hAE: m_disp = 0;
        'h15, 'h75: begin m_op = b; m_need = 2; m_busy = 1; m_params.delete(); end
        'hA0: begin m_op = b; m_need = 1; m_busy = 1; m_params.delete(); end
        default: exp_unk++;
      endcase
    end else begin
      m_params.push_back(b);
      if (m_params.size() == m_need) begin
        m_busy = 0;
        if (m_op == 'hA0) m_remap = m_params[0];
        else begin
          s = clamp_max(m_params[0], (m_op == 'h15) ? 95 : 63);
          e = clamp_max(m_params[1], (m_op == 'h15) ? 95 : 63);
          if (e < s) e = s;
          if (m_op == 'h15) begin m_cs = s; m_ce = e; m_col = s; end
          else begin m_rs = s; m_re = e; m_row = s; end
        end
        m_params.delete();
      end
    end
  endtask

  // Compare process: pulses checked against model queues every cycle
  int  rx_seen = 0, pix_n = 0, ferr_seen = 0, unk_seen = 0;
  int  pix_log[2048];
  bit  idle = 0, have_prev = 0, prev_rxv = 0, prev_rxdc = 0;
  int  prev_col, prev_row, prev_data, v;

  always @(negedge clk) begin
    if (!rst) begin
      have_prev = 0; prev_rxv = 0; prev_rxdc = 0;
    end else begin
      if (rx_valid) begin
        rx_seen++;
        if (rxq.size() == 0) chk("rx_unexpected", 1, 0);
        else begin
          v = rxq.pop_front();
          chk("rx_byte", {rx_dc, rx_byte}, v);
        end
      end
      if (pix_we || (prev_rxv && prev_rxdc))
        chk("pix_we_timing", pix_we, prev_rxv && prev_rxdc);
      if (pix_we) begin
        if (pix_n < 2048) pix_log[pix_n] = pix_col * 65536 + pix_row * 256 + pix_data;
        pix_n++;
        if (pixq.size() == 0) chk("pix_unexpected", 1, 0);
        else begin
          v = pixq.pop_front();
          chk("pix_write", pix_col * 65536 + pix_row * 256 + pix_data, v);
        end
      end else if (have_prev) begin
        chk("pix_hold", pix_col * 65536 + pix_row * 256 + pix_data,
            prev_col * 65536 + prev_row * 256 + prev_data);
      end
      if (unk_cmd) begin
        unk_seen++;
        chk("unk_expected", exp_unk > 0, 1);
        if (exp_unk > 0) exp_unk--;
      end
      if (frame_err) begin
        ferr_seen++;
        chk("ferr_expected", exp_ferr > 0, 1);
        if (exp_ferr > 0) exp_ferr--;
      end
      if (idle) begin
        chk("display_on", disp_on, m_disp);
        chk("remap", remap, m_remap);
        chk("pending_events", rxq.size() + pixq.size() + exp_unk + exp_ferr, 0);
      end
      have_prev = 1; prev_rxv = rx_valid; prev_rxdc = rx_dc;
      prev_col = pix_col; prev_row = pix_row; prev_data = pix_data;
    end
  end

  // SPI mode 0: SCK is 8 i_CLK periods, MOSI changes while SCK is low
  task automatic send_bits(input logic [7:0] b, input int n, input logic d);
    if (cs) begin cs = 1'b0; #40; end
    dc = d;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic send_byte(input int b, input int d);
    model_byte(b, d);
    send_bits(8'(b), 8, d ? 1'b1 : 1'b0);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    #80;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    idle = 1;
    @(posedge clk);
    @(posedge clk);
    idle = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    #1;
    chk("rst_outputs", {rx_valid, rx_byte, rx_dc, pix_we, pix_col, pix_row, pix_data,
                        disp_on, remap, frame_err, unk_cmd}, 0);
    rst = 1'b1;
  endtask

  int base, r, n;

  initial begin
    model_reset();
    do_reset();
    cs_high();

    for (int i = 0; i < 97; i++) send_byte($urandom_range(0, 255), 1);
    settle();
    chk("full_win_p95", pix_log[95] / 256, 95 * 256 + 0);
    chk("full_win_p96", pix_log[96] / 256, 0 * 256 + 1);

    base = rx_seen;
    send_byte('hAF, 0); send_byte('hA0, 0); send_byte('h20, 0);
    settle();
    chk("disp_on_lit", disp_on, 1);
    chk("remap_lit", remap, 'h20);
    chk("rx_count_3", rx_seen - base, 3);

    send_byte('h15, 0); send_byte('h08, 0); send_byte('h0F, 0);
    send_byte('h75, 0); send_byte('h10, 0); send_byte('h17, 0);
    base = pix_n;
    for (int i = 0; i < 65; i++) send_byte(i, 1);
    settle();
    chk("win_first", pix_log[base] / 256, 8 * 256 + 16);
    chk("win_row_end", pix_log[base + 7] / 256, 15 * 256 + 16);
    chk("win_wrap_col", pix_log[base + 8] / 256, 8 * 256 + 17);
    chk("win_last", pix_log[base + 63] / 256, 15 * 256 + 23);
    chk("win_65th", pix_log[base + 64], 8 * 65536 + 16 * 256 + 64);

    cs_high();
    base = rx_seen; n = ferr_seen;
    send_bits(8'hA5, 5, 1'b0);
    exp_ferr++;
    cs_high();
    settle();
    chk("abort_ferr", ferr_seen - n, 1);
    chk("abort_no_rx", rx_seen - base, 0);
    send_byte('hAE, 0);
    settle();
    chk("abort_then_ae", disp_on, 0);

    send_byte('h15, 0); send_byte('h70, 0); send_byte('h05, 0);
    base = pix_n;
    send_byte('h5A, 1);
    settle();
    chk("clamp_col", pix_log[base] / 65536, 95);

    send_bits(8'hFF, 3, 1'b0);
    n = ferr_seen;
    do_reset();
    cs_high();
    settle();
    chk("reset_mid_no_ferr", ferr_seen - n, 0);

    base = pix_n; n = unk_seen;
    send_byte('h15, 0); send_byte('h04, 0); send_byte('h3C, 1); send_byte('h3D, 1);
    send_byte('h81, 0);
    settle();
    chk("abort_pix", pix_log[base], 'h3C);
    chk("abort_win_kept", pix_log[base + 1] / 256, 1 * 256 + 0);
    chk("unknown_pulse", unk_seen - n, 1);

    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: send_byte($urandom_range(0, 255), 1);
        4: send_byte($urandom_range(0, 1) ? 'hAF : 'hAE, 0);
        5, 6: begin
          send_byte((r == 5) ? 'h15 : 'h75, 0);
          send_byte($urandom_range(0, 127), 0);
          if ($urandom_range(0, 3) == 0) send_byte($urandom_range(0, 255), 1);
          else send_byte($urandom_range(0, 127), 0);
        end
        7: begin send_byte('hA0, 0); send_byte($urandom_range(0, 255), 0); end
        8: send_byte($urandom_range(0, 255), 0);
        default: begin
          send_bits(8'($urandom_range(0, 255)), $urandom_range(1, 7), 1'b0);
          exp_ferr++;
          cs_high();
        end
      endcase
      if ($urandom_range(0, 4) == 0) cs_high();
      settle();
    end

    settle();
    chk("final_rx_drained", rxq.size(), 0);
    chk("final_pix_drained", pixq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
